control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Main decoder of the single-cycle RV32I datapath: maps OpCode/Funct3/Funct7 to immediate,
//  ALU, register-file write and branch controls. Decode is combinational; all outputs are
//  registered (1-cycle latency) so the datapath sees stable controls from clk edge to clk edge.
// PARAMETERS
//  none (encodings fixed below)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  OpCode       in   7  instr[6:0]
//  Funct3       in   3  instr[14:12]
//  Funct7       in   7  instr[31:25]
//  ImmSrc       out  3  imm format: 000 I, 001 S, 101 B, 010 U, 110 J
//  ALUASrc      out  1  0 = rs1, 1 = PC
//  ALUBSrc      out  1  0 = rs2, 1 = imm
//  ALUOp        out  4  ALU op: {f7[5],f3} R-type; 0000 ADD; 1001 PASS_B
//  RUDataWrSrc  out  2  00 ALU, 01 data mem, 10 PC+4
//  RUWr         out  1  register-file write enable
//  BrOp         out  5  00000 no branch; 01{f3} conditional; 10000 unconditional jump
// BEHAVIOUR
//  - rst_n low: all outputs 0 immediately, held until first rising clk after release.
//  - Otherwise outputs <= decode(OpCode,Funct3,Funct7) every rising clk; no handshake.
//  - Decode table (ImmSrc,ASrc,BSrc,ALUOp,WrSrc,RUWr,BrOp):
//    R     0110011: 000,0,0,{F7[5],F3},00,1,00000
//    I-ALU 0010011: 000,0,1,{0,F3},00,1,00000; F3=101 -> ALUOp {F7[5],101} (SRLI/SRAI)
//    LOAD  0000011: 000,0,1,0000,01,1,00000
//    STORE 0100011: 001,0,1,0000,00,0,00000
//    BR    1100011: 101,1,1,0000,00,0,{01,F3}  (ALU computes PC+imm)
//    JAL   1101111: 110,1,1,0000,10,1,10000
//    JALR  1100111: 000,0,1,0000,10,1,10000
//    LUI   0110111: 010,0,1,1001,00,1,00000
//    AUIPC 0010111: 010,1,1,0000,00,1,00000
//  - Any other OpCode: all outputs 0 (RUWr=0, BrOp=00000) -> architectural NOP.
//  - Funct7 bits other than [5] ignored; Funct3 ignored where not listed.
//  - Reset asserted mid-operation: outputs clear without waiting for clk.
// CONFIGURATION
//  - CU_ILLEGAL_INSN_EN defined: extra port IllegalInsn out 1, registered with other outputs,
//    reset 0; =1 for unlisted OpCode, R-type with Funct7 not 0000000/0100000 or
//    Funct7=0100000 with F3 not 000/101, BR with F3=010/011, JALR with F3!=000.
//    Decode outputs unchanged (illegal R/I forms still produce table values).
//  - Not defined: port absent, illegal forms silently decode per table.
// TESTING
//  - rst_n=0 with OpCode=0110011 driven -> all outputs 0 with no clk edge; stay 0 while low.
//  - add 0110011/000/0000000 then sub F7=0100000 -> after 1 clk ALUOp 0000 then 1000,
//    RUWr=1, BSrc=0.
//  - addi 0010011/000 -> ImmSrc 000, BSrc 1, ALUOp 0000; srai F3=101 F7=0100000 -> 1101.
//  - beq 1100011/000 -> ImmSrc 101, ASrc 1, RUWr 0, BrOp 01000; bgeu F3=111 -> 01111.
//  - lw/sw/jalr/jal/lui/auipc -> WrSrc 01/00/10/10/00/00, RUWr 1/0/1/1/1/1,
//    ImmSrc 000/001/000/110/010/010, lui ALUOp 1001.
//  - OpCode 1111111 -> all 0 next clk; with CU_ILLEGAL_INSN_EN IllegalInsn=1, then 0 on addi.

Source files
------------

// File: rtl/control_unit.sv
// RV32I main decoder: opcode/funct fields -> imm, ALU, writeback and branch controls.
// One-cycle registered outputs with no handshake; define CU_ILLEGAL_INSN_EN to add the IllegalInsn output.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OpCode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  output logic [2:0] ImmSrc,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [3:0] ALUOp,
  output logic [1:0] RUDataWrSrc,
  output logic       RUWr,
  output logic [4:0] BrOp
`ifdef CU_ILLEGAL_INSN_EN
  ,
  output logic       IllegalInsn
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;

  localparam logic [1:0] WR_ALU = 2'b00;
  localparam logic [1:0] WR_MEM = 2'b01;
  localparam logic [1:0] WR_PC4 = 2'b10;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b10000;

  logic [2:0] w_imm_src;
  logic       w_a_src;
  logic       w_b_src;
  logic [3:0] w_alu_op;
  logic [1:0] w_wr_src;
  logic       w_ru_wr;
  logic [4:0] w_br_op;

  logic [2:0] r_imm_src;
  logic       r_a_src;
  logic       r_b_src;
  logic [3:0] r_alu_op;
  logic [1:0] r_wr_src;
  logic       r_ru_wr;
  logic [4:0] r_br_op;

  always_comb begin
    w_imm_src = IMM_I;
    w_a_src   = 1'b0;
    w_b_src   = 1'b0;
    w_alu_op  = ALU_ADD;
    w_wr_src  = WR_ALU;
    w_ru_wr   = 1'b0;
    w_br_op   = BR_NONE;
    case (OpCode)
      OP_R: begin
        w_alu_op = {Funct7[5], Funct3};
        w_ru_wr  = 1'b1;
      end
      OP_I: begin
        // Only the shift-right form uses Funct7[5] to pick arithmetic vs logical.
        w_b_src  = 1'b1;
        w_alu_op = (Funct3 == 3'b101) ? {Funct7[5], Funct3} : {1'b0, Funct3};
        w_ru_wr  = 1'b1;
      end
      OP_LOAD: begin
        w_b_src  = 1'b1;
        w_wr_src = WR_MEM;
        w_ru_wr  = 1'b1;
      end
      OP_STORE: begin
        w_imm_src = IMM_S;
        w_b_src   = 1'b1;
      end
      OP_BR: begin
        w_imm_src = IMM_B;
        w_a_src   = 1'b1;
        w_b_src   = 1'b1;
        w_br_op   = {2'b01, Funct3};
      end
      OP_JAL: begin
        w_imm_src = IMM_J;
        w_a_src   = 1'b1;
        w_b_src   = 1'b1;
        w_wr_src  = WR_PC4;
        w_ru_wr   = 1'b1;
        w_br_op   = BR_JUMP;
      end
      OP_JALR: begin
        w_b_src  = 1'b1;
        w_wr_src = WR_PC4;
        w_ru_wr  = 1'b1;
        w_br_op  = BR_JUMP;
      end
      OP_LUI: begin
        w_imm_src = IMM_U;
        w_b_src   = 1'b1;
        w_alu_op  = ALU_PASS_B;
        w_ru_wr   = 1'b1;
      end
      OP_AUIPC: begin
        w_imm_src = IMM_U;
        w_a_src   = 1'b1;
        w_b_src   = 1'b1;
        w_ru_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm_src <= 3'b000;
      r_a_src   <= 1'b0;
      r_b_src   <= 1'b0;
      r_alu_op  <= 4'b0000;
      r_wr_src  <= 2'b00;
      r_ru_wr   <= 1'b0;
      r_br_op   <= 5'b00000;
    end else begin
      r_imm_src <= w_imm_src;
      r_a_src   <= w_a_src;
      r_b_src   <= w_b_src;
      r_alu_op  <= w_alu_op;
      r_wr_src  <= w_wr_src;
      r_ru_wr   <= w_ru_wr;
      r_br_op   <= w_br_op;
    end
  end

  assign ImmSrc      = r_imm_src;
  assign ALUASrc     = r_a_src;
  assign ALUBSrc     = r_b_src;
  assign ALUOp       = r_alu_op;
  assign RUDataWrSrc = r_wr_src;
  assign RUWr        = r_ru_wr;
  assign BrOp        = r_br_op;

`ifdef CU_ILLEGAL_INSN_EN
  logic w_illegal;
  logic r_illegal;

  // Flag only; the decode above is left untouched for illegal forms.
  always_comb begin
    w_illegal = 1'b0;
    case (OpCode)
      OP_R: begin
        if (Funct7 == 7'b0100000)
          w_illegal = (Funct3 != 3'b000) && (Funct3 != 3'b101);
        else
          w_illegal = (Funct7 != 7'b0000000);
      end
      OP_BR:   w_illegal = (Funct3 == 3'b010) || (Funct3 == 3'b011);
      OP_JALR: w_illegal = (Funct3 != 3'b000);
      OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_LUI, OP_AUIPC: w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else        r_illegal <= w_illegal;
  end

  assign IllegalInsn = r_illegal;
`else
  logic w_unused_f7;
  assign w_unused_f7 = ^{Funct7[6], Funct7[4:0]};
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed checks of the control_unit decoder: reset, each opcode class, illegal forms.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] OpCode = 7'b0;
  logic [2:0] Funct3 = 3'b0;
  logic [6:0] Funct7 = 7'b0;
  logic [2:0] ImmSrc;
  logic       ALUASrc;
  logic       ALUBSrc;
  logic [3:0] ALUOp;
  logic [1:0] RUDataWrSrc;
  logic       RUWr;
  logic [4:0] BrOp;
`ifdef CU_ILLEGAL_INSN_EN
  logic       IllegalInsn;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Packed view: {ImmSrc, ASrc, BSrc, ALUOp, WrSrc, RUWr, BrOp}
  logic [16:0] obs;
  assign obs = {ImmSrc, ALUASrc, ALUBSrc, ALUOp, RUDataWrSrc, RUWr, BrOp};

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .OpCode      (OpCode),
    .Funct3      (Funct3),
    .Funct7      (Funct7),
    .ImmSrc      (ImmSrc),
    .ALUASrc     (ALUASrc),
    .ALUBSrc     (ALUBSrc),
    .ALUOp       (ALUOp),
    .RUDataWrSrc (RUDataWrSrc),
    .RUWr        (RUWr),
    .BrOp        (BrOp)
`ifdef CU_ILLEGAL_INSN_EN
    ,
    .IllegalInsn (IllegalInsn)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    OpCode = op;
    Funct3 = f3;
    Funct7 = f7;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    OpCode = 7'b0110011;
    rst_n  = 1'b0;
    #1;
    n_total++;
    if (obs !== 17'b0) $display("FAIL reset_async: got %b want %b", obs, 17'b0);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (obs !== 17'b0) $display("FAIL reset_hold: got %b want %b", obs, 17'b0);
    else n_pass++;
`ifdef CU_ILLEGAL_INSN_EN
    n_total++;
    if (IllegalInsn !== 1'b0) $display("FAIL reset_illegal: got %b want 0", IllegalInsn);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rtype;
    logic [6:0]  f7 [4] = '{7'b0000000, 7'b0100000, 7'b0100000, 7'b1111111};
    logic [2:0]  f3 [4] = '{3'b000,     3'b000,     3'b101,     3'b000};
    logic [16:0] ex [4] = '{17'b000_0_0_0000_00_1_00000,
                            17'b000_0_0_1000_00_1_00000,
                            17'b000_0_0_1101_00_1_00000,
                            17'b000_0_0_1000_00_1_00000};
    for (int i = 0; i < 4; i++) begin
      step(7'b0110011, f3[i], f7[i]);
      n_total++;
      if (obs !== ex[i]) $display("FAIL rtype[%0d]: got %b want %b", i, obs, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ialu;
    logic [6:0]  f7 [4] = '{7'b0000000, 7'b0100000, 7'b0000000, 7'b0100000};
    logic [2:0]  f3 [4] = '{3'b000,     3'b101,     3'b101,     3'b010};
    logic [16:0] ex [4] = '{17'b000_0_1_0000_00_1_00000,
                            17'b000_0_1_1101_00_1_00000,
                            17'b000_0_1_0101_00_1_00000,
                            17'b000_0_1_0010_00_1_00000};
    for (int i = 0; i < 4; i++) begin
      step(7'b0010011, f3[i], f7[i]);
      n_total++;
      if (obs !== ex[i]) $display("FAIL ialu[%0d]: got %b want %b", i, obs, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch;
    logic [2:0]  f3 [3] = '{3'b000, 3'b111, 3'b001};
    logic [16:0] ex [3] = '{17'b101_1_1_0000_00_0_01000,
                            17'b101_1_1_0000_00_0_01111,
                            17'b101_1_1_0000_00_0_01001};
    for (int i = 0; i < 3; i++) begin
      step(7'b1100011, f3[i], 7'b0100000);
      n_total++;
      if (obs !== ex[i]) $display("FAIL branch[%0d]: got %b want %b", i, obs, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mem_jump;
    logic [6:0]  op [6] = '{7'b0000011, 7'b0100011, 7'b1100111,
                            7'b1101111, 7'b0110111, 7'b0010111};
    logic [16:0] ex [6] = '{17'b000_0_1_0000_01_1_00000,
                            17'b001_0_1_0000_00_0_00000,
                            17'b000_0_1_0000_10_1_10000,
                            17'b110_1_1_0000_10_1_10000,
                            17'b010_0_1_1001_00_1_00000,
                            17'b010_1_1_0000_00_1_00000};
    for (int i = 0; i < 6; i++) begin
      step(op[i], 3'b010, 7'b0100000);
      n_total++;
      if (obs !== ex[i]) $display("FAIL memjump[%0d]: got %b want %b", i, obs, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_illegal;
    logic [6:0]  op [8] = '{7'b1111111, 7'b0010011, 7'b0110011, 7'b0110011,
                            7'b1100011, 7'b1100111, 7'b0000000, 7'b0110011};
    logic [2:0]  f3 [8] = '{3'b000, 3'b000, 3'b000, 3'b001,
                            3'b010, 3'b001, 3'b000, 3'b101};
    logic [6:0]  f7 [8] = '{7'b0000000, 7'b0000000, 7'b0000001, 7'b0100000,
                            7'b0000000, 7'b0000000, 7'b0000000, 7'b0100000};
    logic [16:0] ex [8] = '{17'b0,
                            17'b000_0_1_0000_00_1_00000,
                            17'b000_0_0_0000_00_1_00000,
                            17'b000_0_0_1001_00_1_00000,
                            17'b101_1_1_0000_00_0_01010,
                            17'b000_0_1_0000_10_1_10000,
                            17'b0,
                            17'b000_0_0_1101_00_1_00000};
    logic        il [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(op[i], f3[i], f7[i]);
      n_total++;
      if (obs !== ex[i]) $display("FAIL illegal_dec[%0d]: got %b want %b", i, obs, ex[i]);
      else n_pass++;
`ifdef CU_ILLEGAL_INSN_EN
      n_total++;
      if (IllegalInsn !== il[i]) $display("FAIL illegal_flag[%0d]: got %b want %b", i, IllegalInsn, il[i]);
      else n_pass++;
`else
      if (il[i] === 1'bx) $display("note: illegal table entry %0d undefined", i);
`endif
    end
  endtask

  task automatic test_mid_reset;
    step(7'b0110011, 3'b000, 7'b0000000);
    n_total++;
    if (RUWr !== 1'b1) $display("FAIL midrst_pre: got %b want 1", RUWr);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs !== 17'b0) $display("FAIL midrst_clear: got %b want %b", obs, 17'b0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step(7'b0110111, 3'b000, 7'b0000000);
    n_total++;
    if (obs !== 17'b010_0_1_1001_00_1_00000)
      $display("FAIL midrst_recover: got %b want %b", obs, 17'b010_0_1_1001_00_1_00000);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_ialu;
    test_branch;
    test_mem_jump;
    test_illegal;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
